quad_input_filter: RTL and testbench

QUAD_INPUT_FILTER -- requirements
Module: quad_input_filter

---
 rtl/quad_input_filter.sv | 146 ++++++++++++++
 tb/tb_quad_input_filter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/quad_input_filter.sv
// Synchronize, tick-filter and quadrature-decode raw A/B/Z encoder pins.
// Optional saturating error counter enabled by macro QUAD_INPUT_FILTER_ERRCNT_EN.
module quad_input_filter #(
    parameter int DIV        = 16,
    parameter int FILTER_LEN = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_in,
    input  logic       b_in,
    input  logic       z_in,
    output logic       a,
    output logic       b,
    output logic       z,
    output logic       step,
    output logic       dir,
    output logic       index,
    output logic       err,
    output logic [7:0] err_count
);

    // Channel order in all 3-bit vectors: bit0 = a, bit1 = b, bit2 = z.
    logic [2:0]  w_raw;
    logic [2:0]  w_filt;
    logic [2:0]  w_prev;
    logic [1:0]  w_chg;
    logic [15:0] r_presc;
    logic        r_tick;
    logic        r_init;
    logic        r_step;
    logic        r_dir;
    logic        r_index;
    logic        r_err;

    assign w_raw = {z_in, b_in, a_in};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else if (r_presc == 16'(DIV - 1)) begin
            r_presc <= '0;
            r_tick  <= 1'b1;
        end else begin
            r_presc <= r_presc + 16'd1;
            r_tick  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_init <= 1'b1;
        end else if (r_tick) begin
            r_init <= 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            logic       r_meta;
            logic       r_sync;
            logic       r_filt;
            logic       r_prev;
            logic [7:0] r_cnt;

            // r_prev trails r_filt by one clk so the decoder sees each filtered edge once.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_meta <= 1'b0;
                    r_sync <= 1'b0;
                    r_filt <= 1'b0;
                    r_prev <= 1'b0;
                    r_cnt  <= '0;
                end else begin
                    r_meta <= w_raw[gi];
                    r_sync <= r_meta;
                    r_prev <= r_filt;
                    if (r_tick) begin
                        if (r_init) begin
                            // Load both so the initial level never looks like an edge.
                            r_filt <= r_sync;
                            r_prev <= r_sync;
                            r_cnt  <= '0;
                        end else if (r_sync != r_filt) begin
                            if (r_cnt == 8'(FILTER_LEN - 1)) begin
                                r_filt <= r_sync;
                                r_cnt  <= '0;
                            end else begin
                                r_cnt <= r_cnt + 8'd1;
                            end
                        end else begin
                            r_cnt <= '0;
                        end
                    end
                end
            end

            assign w_filt[gi] = r_filt;
            assign w_prev[gi] = r_prev;
        end
    endgenerate

    assign w_chg = w_filt[1:0] ^ w_prev[1:0];

    // Forward order 00->10->11->01->00 means new a differs from old b.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_step  <= 1'b0;
            r_dir   <= 1'b0;
            r_index <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_step  <= (w_chg == 2'b01) || (w_chg == 2'b10);
            r_err   <= (w_chg == 2'b11);
            r_index <= w_filt[2] & ~w_prev[2];
            if ((w_chg == 2'b01) || (w_chg == 2'b10)) begin
                r_dir <= w_filt[0] ^ w_prev[1];
            end
        end
    end

`ifdef QUAD_INPUT_FILTER_ERRCNT_EN
    logic [7:0] r_err_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_count <= '0;
        end else if (r_err && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = r_err_count;
`else
    assign err_count = 8'd0;
`endif

    assign a     = w_filt[0];
    assign b     = w_filt[1];
    assign z     = w_filt[2];
    assign step  = r_step;
    assign dir   = r_dir;
    assign index = r_index;
    assign err   = r_err;

endmodule

// File: tb/tb_quad_input_filter.sv
// Scoreboard bench for quad_input_filter: expected pulses queued at stimulus, popped on DUT pulses.
module tb_quad_input_filter;

    localparam int DIV  = 16;
    localparam int FLEN = 4;
    localparam int TICK = DIV;

    logic       clk;
    logic       reset;
    logic       a_in;
    logic       b_in;
    logic       z_in;
    logic       a;
    logic       b;
    logic       z;
    logic       step;
    logic       dir;
    logic       index;
    logic       err;
    logic [7:0] err_count;

    int n_compared;
    int n_mismatched;
    int n_err_pushed;

    // Event encoding: {step, dir-if-step, err, index}.
    logic [3:0] sb_q[$];

    quad_input_filter #(.DIV(DIV), .FILTER_LEN(FLEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .a_in      (a_in),
        .b_in      (b_in),
        .z_in      (z_in),
        .a         (a),
        .b         (b),
        .z         (z),
        .step      (step),
        .dir       (dir),
        .index     (index),
        .err       (err),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every pulse must match the head of the scoreboard and come 1 clk after its edge.
    logic [1:0] m_last_ab = 2'b00;
    logic       m_last_z  = 1'b0;
    int         m_age_ab  = 0;
    int         m_age_z   = 0;

    always @(negedge clk) begin
        logic [3:0] ev;
        logic [3:0] exp_ev;
        if ({a, b} != m_last_ab) m_age_ab = 0;
        else m_age_ab++;
        if (z != m_last_z) m_age_z = 0;
        else m_age_z++;
        m_last_ab = {a, b};
        m_last_z  = z;
        if (!reset && (step || err || index)) begin
            ev = {step, step & dir, err, index};
            if (sb_q.size() == 0) begin
                check("unexpected_evt", 32'(ev), 32'd0);
            end else begin
                exp_ev = sb_q.pop_front();
                check("event", 32'(ev), 32'(exp_ev));
            end
            if (step || err) check("ab_latency", m_age_ab, 1);
            if (index) check("z_latency", m_age_z, 1);
        end
    end

    task automatic drive_ab(input logic va, input logic vb, input int hold_ticks);
        logic [1:0] old_ab;
        logic [1:0] chg;
        old_ab = {a_in, b_in};
        chg    = old_ab ^ {va, vb};
        if (chg == 2'b11) begin
            sb_q.push_back(4'b0010);
            n_err_pushed++;
        end else if (chg != 2'b00) begin
            // Forward when the new a differs from the old b.
            sb_q.push_back({1'b1, va ^ old_ab[0], 2'b00});
        end
        a_in = va;
        b_in = vb;
        wait_clk(hold_ticks * TICK);
    endtask

    initial begin
        logic [7:0] exp_cnt;
        n_compared   = 0;
        n_mismatched = 0;
        n_err_pushed = 0;
        reset = 1'b1;
        a_in  = 1'b1;
        b_in  = 1'b1;
        z_in  = 1'b0;

        // Reset state with inputs high.
        wait_clk(4);
        @(negedge clk);
        check("rst_a", 32'(a), 32'd0);
        check("rst_b", 32'(b), 32'd0);
        check("rst_z", 32'(z), 32'd0);
        check("rst_pulses", 32'({step, index, err}), 32'd0);
        check("rst_dir", 32'(dir), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Init load: a=b=1 after the first tick, no pulses (monitor flags any).
        wait_clk(22);
        check("init_a", 32'(a), 32'd1);
        check("init_b", 32'(b), 32'd1);

        // Restart from 00 through a fresh init load.
        a_in  = 1'b0;
        b_in  = 1'b0;
        reset = 1'b1;
        wait_clk(3);
        reset = 1'b0;
        wait_clk(22);
        check("init00_ab", 32'({a, b}), 32'd0);

        // Glitch of 3 ticks is rejected.
        a_in = 1'b1;
        wait_clk(3 * TICK);
        a_in = 1'b0;
        wait_clk(8 * TICK);
        check("glitch_a", 32'(a), 32'd0);

        // Forward rotation.
        drive_ab(1'b1, 1'b0, 8);
        check("fwd_ab1", 32'({a, b}), 32'd2);
        drive_ab(1'b1, 1'b1, 8);
        drive_ab(1'b0, 1'b1, 8);
        drive_ab(1'b0, 1'b0, 8);
        check("fwd_end_ab", 32'({a, b}), 32'd0);
        check("fwd_dir_hold", 32'(dir), 32'd1);

        // Reverse rotation.
        drive_ab(1'b0, 1'b1, 8);
        drive_ab(1'b1, 1'b1, 8);
        drive_ab(1'b1, 1'b0, 8);
        drive_ab(1'b0, 1'b0, 8);
        check("rev_end_ab", 32'({a, b}), 32'd0);
        check("rev_dir_hold", 32'(dir), 32'd0);

        // Index: one pulse on rise, none on fall.
        sb_q.push_back(4'b0001);
        z_in = 1'b1;
        wait_clk(8 * TICK);
        check("idx_z_high", 32'(z), 32'd1);
        z_in = 1'b0;
        wait_clk(8 * TICK);
        check("idx_z_low", 32'(z), 32'd0);

        // Mid-filter reset: partial count lost, init load brings a=1 with no step.
        a_in = 1'b1;
        wait_clk(2 * TICK + 4);
        check("pend_a", 32'(a), 32'd0);
        reset = 1'b1;
        wait_clk(2);
        check("midrst_a", 32'(a), 32'd0);
        reset = 1'b0;
        wait_clk(4);
        check("midrst_a_before_init", 32'(a), 32'd0);
        wait_clk(20);
        check("midrst_init_a", 32'(a), 32'd1);
        drive_ab(1'b0, 1'b0, 8);
        check("midrst_back_ab", 32'({a, b}), 32'd0);

        // Simultaneous A/B toggles: 300 err pulses, no steps.
        for (int i = 0; i < 300; i++) begin
            drive_ab(~a_in, ~b_in, FLEN + 1);
        end
        wait_clk(4 * TICK);
`ifdef QUAD_INPUT_FILTER_ERRCNT_EN
        exp_cnt = (n_err_pushed > 255) ? 8'd255 : 8'(n_err_pushed);
`else
        exp_cnt = 8'd0;
`endif
        check("err_count", 32'(err_count), 32'(exp_cnt));
        check("sb_leftover", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
